// File: rtl/rectifier_sensing_avg.sv
// N_CH-channel ADC block averager with per-channel offset/gain scaling through one
// shared multiplier; publishes saturated signed results with a one-cycle valid pulse.
module rectifier_sensing_avg #(
    parameter int N_CH      = 2,
    parameter int ADC_W     = 8,
    parameter int AVG_LOG   = 2,
    parameter int GAIN_W    = 12,
    parameter int GAIN_FRAC = 4,
    parameter int OUT_W     = 12
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic                      i_sample,
    input  logic [N_CH*ADC_W-1:0]     i_adc,
    input  logic [N_CH*(ADC_W+1)-1:0] i_offset,
    input  logic [N_CH*GAIN_W-1:0]    i_gain,
    input  logic                      i_clear,
    output logic [N_CH*OUT_W-1:0]     o_value,
    output logic                      o_valid,
    output logic [N_CH-1:0]           o_sat,
    output logic                      o_overrun,
    output logic                      o_busy
);

    localparam int ACC_W  = ADC_W + AVG_LOG;
    localparam int OFF_W  = ADC_W + 1;
    localparam int DIFF_W = ADC_W + 2;
    localparam int PROD_W = DIFF_W + GAIN_W;
    localparam int CNT_W  = (AVG_LOG > 0) ? AVG_LOG : 1;
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'((1 << AVG_LOG) - 1);
    localparam logic [CH_W-1:0]          CH_LAST  = CH_W'(N_CH - 1);
    localparam logic signed [PROD_W-1:0] OUT_MAX  = PROD_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] OUT_MIN  = PROD_W'(-(1 << (OUT_W - 1)));

    typedef enum logic [1:0] {IDLE, SCALE, DONE} state_t;

    state_t state, state_next;

    logic [ACC_W-1:0] acc [N_CH];
    logic [ACC_W-1:0] sum [N_CH];
    logic [ADC_W-1:0] avg [N_CH];
    logic [CNT_W-1:0] cnt;
    logic [CH_W-1:0]  ch;
    logic [OUT_W-1:0] stage_val [N_CH];
    logic [N_CH-1:0]  stage_sat;

    logic strobe, block_end;

    assign strobe    = i_sample & i_enable;
    assign block_end = strobe && (cnt == CNT_LAST);
    assign o_busy    = (state != IDLE);

    always_comb begin
        for (int c = 0; c < N_CH; c++)
            sum[c] = acc[c] + ACC_W'(i_adc[c*ADC_W +: ADC_W]);
    end

    // Accumulation runs independently of scaling; a block end only lands in avg when idle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt <= '0;
            for (int c = 0; c < N_CH; c++) begin
                acc[c] <= '0;
                avg[c] <= '0;
            end
        end else if (strobe) begin
            cnt <= block_end ? '0 : cnt + 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                if (block_end) begin
                    acc[c] <= '0;
                    if (state == IDLE)
                        avg[c] <= sum[c][ACC_W-1:AVG_LOG];
                end else begin
                    acc[c] <= sum[c];
                end
            end
        end
    end

    logic [ADC_W-1:0]         avg_sel;
    logic signed [OFF_W-1:0]  off_sel;
    logic signed [GAIN_W-1:0] gain_sel;
    logic signed [DIFF_W-1:0] diff;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] res;
    logic [OUT_W-1:0]         clamped;
    logic                     clip;

    always_comb begin
        avg_sel  = avg[ch];
        off_sel  = i_offset[ch*OFF_W +: OFF_W];
        gain_sel = i_gain[ch*GAIN_W +: GAIN_W];
        diff     = $signed({2'b00, avg_sel}) - DIFF_W'(off_sel);
        prod     = PROD_W'(diff) * PROD_W'(gain_sel);
        res      = prod >>> GAIN_FRAC;
        clip     = 1'b0;
        clamped  = res[OUT_W-1:0];
        if (res > OUT_MAX) begin
            clamped = OUT_MAX[OUT_W-1:0];
            clip    = 1'b1;
        end else if (res < OUT_MIN) begin
            clamped = OUT_MIN[OUT_W-1:0];
            clip    = 1'b1;
        end
    end

    // NOTE: next-state logic assigns its default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (block_end) state_next = SCALE;
            SCALE:   if (ch == CH_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    // NOTE: the staging array is a handful of flops, not a RAM, so it is reset along with the rest.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            ch        <= '0;
            stage_sat <= '0;
            o_value   <= '0;
            o_sat     <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
            for (int c = 0; c < N_CH; c++)
                stage_val[c] <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: ch <= '0;
                SCALE: begin
                    stage_val[ch] <= clamped;
                    stage_sat[ch] <= clip;
                    ch            <= ch + 1'b1;
                end
                DONE: begin
                    for (int c = 0; c < N_CH; c++)
                        o_value[c*OUT_W +: OUT_W] <= stage_val[c];
                    o_sat   <= stage_sat;
                    o_valid <= 1'b1;
                end
                default: ch <= '0;
            endcase
            if (block_end && state != IDLE)
                o_overrun <= 1'b1;
            else if (i_clear)
                o_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rectifier_sensing_avg.sv
// Directed bench: table of 4-strobe blocks for the default instance, hand sequences for
// reset/enable corner cases, and an AVG_LOG=0 instance for the overrun behaviour.
module tb_rectifier_sensing_avg;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_enable = 1'b1;
    logic        i_sample = 1'b0;
    logic        sample0 = 1'b0;
    logic        i_clear = 1'b0;
    logic        clear0 = 1'b0;
    logic [15:0] i_adc = '0;
    logic [17:0] i_offset = '0;
    logic [23:0] i_gain = '0;

    logic [23:0] o_value, value0;
    logic        o_valid, valid0;
    logic [1:0]  o_sat, sat0;
    logic        o_overrun, overrun0;
    logic        o_busy, busy0;

    int checks = 0;
    int errors = 0;

    always #5 i_clock = ~i_clock;

    rectifier_sensing_avg dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_sample(i_sample),
        .i_adc(i_adc), .i_offset(i_offset), .i_gain(i_gain), .i_clear(i_clear),
        .o_value(o_value), .o_valid(o_valid), .o_sat(o_sat), .o_overrun(o_overrun),
        .o_busy(o_busy)
    );

    rectifier_sensing_avg #(.AVG_LOG(0)) dut0 (
        .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_sample(sample0),
        .i_adc(i_adc), .i_offset(i_offset), .i_gain(i_gain), .i_clear(clear0),
        .o_value(value0), .o_valid(valid0), .o_sat(sat0), .o_overrun(overrun0),
        .o_busy(busy0)
    );

    typedef struct {
        string       name;
        logic [31:0] s0;
        logic [31:0] s1;
        int          off0, off1, g0, g1;
        int          e0, e1;
        logic [1:0]  esat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ch_val(input logic [23:0] v, input int c);
        logic [11:0] f;
        f = v[c*12 +: 12];
        return int'($signed(f));
    endfunction

    task automatic set_coef(input int off0, input int off1, input int g0, input int g1);
        i_offset = {9'(off1), 9'(off0)};
        i_gain   = {12'(g1), 12'(g0)};
    endtask

    task automatic do_strobe(input logic [7:0] a0, input logic [7:0] a1);
        @(negedge i_clock);
        i_adc    = {a1, a0};
        i_sample = 1'b1;
        @(negedge i_clock);
        i_sample = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = 0;
        do begin
            @(negedge i_clock);
            lat++;
        end while (!o_valid && lat < budget);
    endtask

    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge i_clock);
            if (o_valid) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[4];
        int   lat, cnt;
        int   got[$];

        vecs[0] = '{"nominal",   32'hC8C8C8C8, 32'h64646464, 154,    0, 368,   368,  1058, 2047, 2'b10};
        vecs[1] = '{"floor_avg", 32'h0D0C0B0A, 32'h00000000,   0,    0,  16,    16,    11,    0, 2'b00};
        vecs[2] = '{"negative",  32'h64646464, 32'h64646464, 154,    0, 368, -2048, -1242, -2048, 2'b10};
        vecs[3] = '{"floor_neg", 32'h00000000, 32'hFFFFFFFF,   1, -256,   1,     1,    -1,   31, 2'b00};

        repeat (3) @(negedge i_clock);
        i_reset = 1'b0;
        check("rst_value", int'(o_value), 0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_sat", int'(o_sat), 0);
        check("rst_overrun", int'(o_overrun), 0);
        check("rst_busy", int'(o_busy), 0);

        for (int i = 0; i < 4; i++) begin
            set_coef(vecs[i].off0, vecs[i].off1, vecs[i].g0, vecs[i].g1);
            for (int k = 0; k < 4; k++)
                do_strobe(vecs[i].s0[8*k +: 8], vecs[i].s1[8*k +: 8]);
            wait_valid(20, lat);
            check({vecs[i].name, "_valid"}, int'(o_valid), 1);
            check({vecs[i].name, "_latency"}, lat, 3);
            check({vecs[i].name, "_ch0"}, ch_val(o_value, 0), vecs[i].e0);
            check({vecs[i].name, "_ch1"}, ch_val(o_value, 1), vecs[i].e1);
            check({vecs[i].name, "_sat"}, int'(o_sat), int'(vecs[i].esat));
            @(negedge i_clock);
            check({vecs[i].name, "_pulse"}, int'(o_valid), 0);
            check({vecs[i].name, "_hold"}, ch_val(o_value, 0), vecs[i].e0);
        end

        // Reset in the middle of SCALE.
        set_coef(154, 0, 368, 368);
        for (int k = 0; k < 4; k++) do_strobe(8'd200, 8'd100);
        check("mid_busy", int'(o_busy), 1);
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        check("mid_rst_value", int'(o_value), 0);
        check("mid_rst_valid", int'(o_valid), 0);
        check("mid_rst_sat", int'(o_sat), 0);
        check("mid_rst_busy", int'(o_busy), 0);
        count_valid(8, cnt);
        check("mid_rst_no_valid", cnt, 0);

        // Counter restarts after reset: 2 strobes, reset, then 3 must not finish a block.
        do_strobe(8'd200, 8'd100);
        do_strobe(8'd200, 8'd100);
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        for (int k = 0; k < 3; k++) do_strobe(8'd200, 8'd100);
        count_valid(6, cnt);
        check("restart_no_valid", cnt, 0);
        do_strobe(8'd200, 8'd100);
        wait_valid(20, lat);
        check("restart_valid", int'(o_valid), 1);
        check("restart_ch0", ch_val(o_value, 0), 1058);
        check("restart_ch1", ch_val(o_value, 1), 2047);

        // Enable gating: held count resumes, disabled samples are not accumulated.
        set_coef(0, 0, 16, 16);
        do_strobe(8'd100, 8'd40);
        do_strobe(8'd100, 8'd40);
        i_enable = 1'b0;
        for (int k = 0; k < 6; k++) do_strobe(8'd255, 8'd255);
        count_valid(6, cnt);
        check("disabled_no_valid", cnt, 0);
        i_enable = 1'b1;
        do_strobe(8'd100, 8'd40);
        count_valid(5, cnt);
        check("resume_no_early_valid", cnt, 0);
        do_strobe(8'd100, 8'd40);
        wait_valid(20, lat);
        check("resume_valid", int'(o_valid), 1);
        check("resume_ch0", ch_val(o_value, 0), 100);
        check("resume_ch1", ch_val(o_value, 1), 40);

        // Overrun on the AVG_LOG=0 instance: strobes every 2 cycles.
        check("ovr_start", int'(overrun0), 0);
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge i_clock);
            if (valid0) got.push_back(ch_val(value0, 0));
            sample0 = (cyc % 2 == 0) && (cyc < 12);
            i_adc   = {8'd0, 8'((cyc / 2 + 1) * 10)};
        end
        sample0 = 1'b0;
        check("ovr_valid_count", got.size(), 3);
        check("ovr_res0", (got.size() > 0) ? got[0] : -1, 10);
        check("ovr_res1", (got.size() > 1) ? got[1] : -1, 30);
        check("ovr_res2", (got.size() > 2) ? got[2] : -1, 50);
        check("ovr_flag", int'(overrun0), 1);
        clear0 = 1'b1;
        @(negedge i_clock);
        clear0 = 1'b0;
        check("ovr_cleared", int'(overrun0), 0);

        // Clear coinciding with a new overrun: set wins.
        i_adc   = {8'd0, 8'd70};
        sample0 = 1'b1;
        @(negedge i_clock);
        sample0 = 1'b0;
        @(negedge i_clock);
        i_adc   = {8'd0, 8'd90};
        sample0 = 1'b1;
        clear0  = 1'b1;
        @(negedge i_clock);
        sample0 = 1'b0;
        clear0  = 1'b0;
        check("ovr_set_wins", int'(overrun0), 1);
        repeat (4) @(negedge i_clock);
        check("ovr_kept_value", ch_val(value0, 0), 70);
        clear0 = 1'b1;
        @(negedge i_clock);
        clear0 = 1'b0;
        check("ovr_final_clear", int'(overrun0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rectifier_sensing_avg.md
Name: rectifier_sensing_avg

Overview:
Parametrised successor to the single-channel rectifier current/voltage sensing converters. It captures N_CH parallel AD7822-style 8-bit conversions on a sample strobe and block-averages 2^AVG_LOG samples per channel. It then applies a runtime per-channel offset and fixed-point gain through one shared, time-multiplexed multiplier and publishes saturated signed engineering values with a valid pulse. It sits between the ADC interface logic and the controller/display path.

Parameters:
N_CH, 2, number of ADC channels (1..8)
ADC_W, 8, ADC sample width, unsigned
AVG_LOG, 2, log2 of samples per average block (0..6)
GAIN_W, 12, gain width, signed
GAIN_FRAC, 4, fractional bits in gain
OUT_W, 12, output width per channel, signed

Ports:
i_clock  in  1  system clock; all logic on the rising edge
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  when low, strobes are ignored and the accumulator and counter hold
i_sample  in  1  one-cycle strobe: i_adc is valid this cycle
i_adc  in  N_CH*ADC_W  packed channel samples, ch0 in the LSBs
i_offset  in  N_CH*(ADC_W+1)  packed signed per-channel offsets
i_gain  in  N_CH*GAIN_W  packed signed per-channel gains, Q(GAIN_W-GAIN_FRAC).GAIN_FRAC
i_clear  in  1  clears o_overrun
o_value  out  N_CH*OUT_W  packed signed results
o_valid  out  1  one-cycle pulse when o_value updates
o_sat  out  N_CH  per-channel saturation flags for the current o_value
o_overrun  out  1  sticky: a block completed while scaling was busy
o_busy  out  1  high in SCALE or DONE

Behaviour:
- Reset (synchronous, highest priority, also mid-operation): accumulators, sample counter, staging registers, o_value, o_sat, o_valid, o_overrun and o_busy all go to 0; state goes to IDLE.
- Accumulation:
  - One accumulator per channel, ADC_W+AVG_LOG bits, unsigned.
  - Each i_sample & i_enable adds i_adc[ch] and increments the counter (AVG_LOG bits, wraps).
  - On the strobe where counter == 2^AVG_LOG-1 (block end):
    - avg[ch] <= (acc[ch]+i_adc[ch]) >> AVG_LOG (floor).
    - Accumulators and counter clear in the same edge.
  - With AVG_LOG=0, every strobe is a block end.
- Accumulation continues during SCALE/DONE (double-buffered snapshot).
- State machine:
  - IDLE: on block end go to SCALE with ch=0.
  - SCALE: one channel per cycle.
    - diff = avg - offset, signed ADC_W+2 bits.
    - prod = diff*gain, signed ADC_W+2+GAIN_W bits.
    - res = prod >>> GAIN_FRAC (arithmetic, floors toward -inf).
    - Clamp res to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; set the staging sat bit if clamped.
    - Store to staging[ch]. After ch = N_CH-1, go to DONE.
  - DONE: o_value <= staging, o_sat <= staging sat bits, o_valid <= 1 for one cycle; go to IDLE.
- Latency: block-end capture edge E0; staging written at E1..E_N_CH; o_value/o_valid update at edge E_(N_CH+1).
- o_value holds until the next DONE.
- Overrun: a block end while in SCALE or DONE discards that snapshot (the in-flight scaling continues unchanged) and sets o_overrun.
  - o_overrun clears only on i_clear or reset.
  - If i_clear and a new overrun coincide, set wins.
- Offsets and gains are sampled in the SCALE cycle of their channel; changes mid-scale affect only channels not yet processed.
- i_enable low during SCALE does not stop scaling; it only blocks new strobes.

Test Plan:
- Defaults; ch0 constant 200, offset 154, gain 368 (23.0); ch1 constant 100, offset 0, gain 368; four strobes -> o_valid pulse 3 cycles after the 4th strobe edge; ch0 = 1058, o_sat[0]=0; ch1 saturates to 2047, o_sat[1]=1.
- ch0 samples 10, 11, 12, 13, offset 0, gain 16 -> ch0 = 11 (floor of 46/4).
- ch0 constant 100, offset 154, gain 368 -> -1242; gain -2048 with diff 100 -> -2048, sat=1.
- AVG_LOG=0, strobes every 2 cycles -> o_overrun=1, dropped results absent, no extra o_valid; i_clear -> o_overrun=0.
- i_reset asserted during SCALE -> next cycle all outputs 0, state IDLE, no o_valid; counter restarts, so the next result needs 4 fresh strobes.
- i_enable=0 with strobes active -> no accumulation and no o_valid; re-enable -> the count resumes from its held value.
